// File: rtl/complete_broadcast.sv
// Completion/broadcast stage: buffers FU results in per-FU FIFOs and arbitrates
// them round-robin onto NUM_CDB registered common-data-bus slots.
module complete_broadcast #(
  parameter int unsigned WORD_SIZE  = 32,
  parameter int unsigned NUM_P_REGS = 64,
  parameter int unsigned NUM_ROB    = 16,
  parameter int unsigned NUM_FUS    = 3,
  parameter int unsigned NUM_CDB    = 2,
  parameter int unsigned FIFO_DEPTH = 2,
  localparam int unsigned TW = $clog2(NUM_P_REGS),
  localparam int unsigned RW = $clog2(NUM_ROB)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic [NUM_FUS-1:0]           fu_valid_i,
  output logic [NUM_FUS-1:0]           fu_ready_o,
  input  logic [NUM_FUS*TW-1:0]        fu_dest_i,
  input  logic [NUM_FUS*WORD_SIZE-1:0] fu_result_i,
  input  logic [NUM_FUS*RW-1:0]        fu_rob_i,
  input  logic [NUM_FUS-1:0]           fu_regwrite_i,
  output logic [NUM_CDB-1:0]           cdb_valid_o,
  output logic [NUM_CDB*TW-1:0]        cdb_tag_o,
  output logic [NUM_CDB*WORD_SIZE-1:0] cdb_data_o,
  output logic [NUM_CDB*RW-1:0]        cdb_rob_o,
  output logic [NUM_CDB-1:0]           cdb_regwrite_o
);

  localparam int unsigned EW = TW + WORD_SIZE + RW + 1;
  localparam int unsigned PW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FW = (NUM_FUS > 1) ? $clog2(NUM_FUS) : 1;

  // Entry layout: {regwrite, rob, result, dest}
  localparam int unsigned RES_LSB = TW;
  localparam int unsigned ROB_LSB = TW + WORD_SIZE;
  localparam int unsigned RWB_POS = EW - 1;

  logic [EW-1:0] mem [NUM_FUS][FIFO_DEPTH];
  logic [PW-1:0] wr_ptr [NUM_FUS];
  logic [PW-1:0] rd_ptr [NUM_FUS];
  logic [FW-1:0] rr_ptr;

  logic [NUM_FUS-1:0] empty;
  logic [NUM_FUS-1:0] full;
  logic [NUM_FUS-1:0] push;
  logic [NUM_FUS-1:0] grant;
  logic [AW-1:0]      wr_idx [NUM_FUS];
  logic [AW-1:0]      rd_idx [NUM_FUS];
  logic [EW-1:0]      head   [NUM_FUS];
  logic [EW-1:0]      in_entry [NUM_FUS];

  logic [NUM_CDB-1:0] slot_valid;
  logic [FW-1:0]      slot_fu    [NUM_CDB];
  logic [EW-1:0]      slot_entry [NUM_CDB];
  logic [FW-1:0]      last_fu;
  logic               any_win;
  logic [FW-1:0]      rr_next;

  // FIFO status; full when pointers match except for the wrap bit
  always_comb begin
    for (int unsigned k = 0; k < NUM_FUS; k++) begin
      empty[k]    = (wr_ptr[k] == rd_ptr[k]);
      full[k]     = ((wr_ptr[k] ^ rd_ptr[k]) == PW'(FIFO_DEPTH));
      wr_idx[k]   = AW'(wr_ptr[k] % PW'(FIFO_DEPTH));
      rd_idx[k]   = AW'(rd_ptr[k] % PW'(FIFO_DEPTH));
      head[k]     = mem[k][rd_idx[k]];
      fu_ready_o[k] = ~rst_i & ~full[k];
      push[k]     = fu_valid_i[k] & ~full[k];
      in_entry[k] = {fu_regwrite_i[k], fu_rob_i[k*RW +: RW],
                     fu_result_i[k*WORD_SIZE +: WORD_SIZE], fu_dest_i[k*TW +: TW]};
    end
  end

  // Round-robin scan from rr_ptr; the first NUM_CDB non-empty FIFOs win slots in order
  always_comb begin
    int unsigned cand;
    int unsigned nwin;
    grant      = '0;
    slot_valid = '0;
    last_fu    = '0;
    any_win    = 1'b0;
    nwin       = 0;
    cand       = 0;
    for (int unsigned j = 0; j < NUM_CDB; j++) begin
      slot_fu[j] = '0;
    end
    for (int unsigned i = 0; i < NUM_FUS; i++) begin
      cand = 32'(rr_ptr) + i;
      if (cand >= NUM_FUS) begin
        cand = cand - NUM_FUS;
      end
      if (!empty[cand] && (nwin < NUM_CDB)) begin
        grant[cand]      = 1'b1;
        slot_valid[nwin] = 1'b1;
        slot_fu[nwin]    = FW'(cand);
        last_fu          = FW'(cand);
        any_win          = 1'b1;
        nwin             = nwin + 1;
      end
    end
    for (int unsigned j = 0; j < NUM_CDB; j++) begin
      slot_entry[j] = head[slot_fu[j]];
    end
    rr_next = (last_fu == FW'(NUM_FUS - 1)) ? '0 : last_fu + FW'(1);
  end

  // FIFO pointers; flush empties every FIFO and drops same-cycle pushes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < NUM_FUS; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
      end
    end else if (flush_i) begin
      for (int unsigned k = 0; k < NUM_FUS; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_FUS; k++) begin
        if (push[k]) begin
          wr_ptr[k] <= wr_ptr[k] + PW'(1);
        end
        if (grant[k]) begin
          rd_ptr[k] <= rd_ptr[k] + PW'(1);
        end
      end
    end
  end

  // Result storage needs no reset; validity is tracked by the pointers
  always_ff @(posedge clk_i) begin
    for (int unsigned k = 0; k < NUM_FUS; k++) begin
      if (push[k] && !flush_i) begin
        mem[k][wr_idx[k]] <= in_entry[k];
      end
    end
  end

  // CDB output registers; idle slots keep their last payload
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cdb_valid_o    <= '0;
      cdb_tag_o      <= '0;
      cdb_data_o     <= '0;
      cdb_rob_o      <= '0;
      cdb_regwrite_o <= '0;
      rr_ptr         <= '0;
    end else if (flush_i) begin
      cdb_valid_o <= '0;
    end else begin
      for (int unsigned j = 0; j < NUM_CDB; j++) begin
        cdb_valid_o[j] <= slot_valid[j];
        if (slot_valid[j]) begin
          cdb_tag_o[j*TW +: TW]               <= slot_entry[j][TW-1:0];
          cdb_data_o[j*WORD_SIZE +: WORD_SIZE] <= slot_entry[j][RES_LSB +: WORD_SIZE];
          cdb_rob_o[j*RW +: RW]               <= slot_entry[j][ROB_LSB +: RW];
          cdb_regwrite_o[j]                   <= slot_entry[j][RWB_POS];
        end
      end
      if (any_win) begin
        rr_ptr <= rr_next;
      end
    end
  end

endmodule
